video_linebuf_scaler: RTL and testbench

- Parametrised line-buffer video memory between the line renderer (clk domain) and two display consumers.
- HDMI consumer runs on pixel_clk and upscales with configurable rational X/Y ratios. LCD consumer runs on clk and reads unscaled.
- Storage is a ring of LINES lines with two dual-port RAM copies. Row positions cross clock domains as Gray code.
- Adds write back-pressure (wr_row_limit), overrun/underrun flags and exact end-of-field handling.

---
 rtl/video_linebuf_scaler.sv | 271 +++++++++++++++++++++++++++
 tb/tb_video_linebuf_scaler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_linebuf_scaler.sv
// Line-buffer video memory between the line renderer (clk) and two display
// consumers: an upscaling HDMI reader on pixel_clk and an unscaled LCD reader
// on clk. Storage is a ring of LINES lines held in two dual-port RAM copies;
// row positions cross between the clock domains as Gray code.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   pixel_clk           HDMI pixel clock, asynchronous to clk
//   addr, data_in, wen  renderer write, addr = {y, x}
//   ren, data_out       renderer read-back, 1 clk latency
//   wr_row_limit        highest row the renderer may currently write
//   wr_overrun          1-cycle pulse when a write is dropped
//   curr_vid_row        HDMI source row, synchronised into clk
//   next_field_out      next_field synchronised into clk
//   lcd_next_pixel      LCD pixel request
//   lcd_newfield        1-cycle pulse when the LCD stream wraps to row 0
//   lcd_wait            LCD blocked behind the HDMI row
//   lcd_pixel           LCD pixel, 1 clk after its address changes
//   fetch_next, next_line, next_field   HDMI timing strobes (pixel_clk)
//   hdmi_pixel          HDMI pixel, 1 pixel_clk after its address changes
//   hdmi_underflow      sticky until next_field: HDMI row ran past the
//                       renderer's last-written row
module video_linebuf_scaler #(
   parameter int unsigned PIX_W    = 24,
   parameter int unsigned FB_W     = 480,
   parameter int unsigned FB_H     = 320,
   parameter int unsigned XB       = 9,
   parameter int unsigned YB       = 11,
   parameter int unsigned LINES    = 4,
   parameter int unsigned X_ADV    = 3,
   parameter int unsigned X_PER    = 4,
   parameter int unsigned Y_ADV    = 2,
   parameter int unsigned Y_PER    = 3,
   parameter int unsigned TOP_SKIP = 38
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pixel_clk,
   input  logic [YB+XB-1:0]    addr,
   input  logic [PIX_W-1:0]    data_in,
   input  logic                wen,
   input  logic                ren,
   output logic [PIX_W-1:0]    data_out,
   output logic [YB-1:0]       wr_row_limit,
   output logic                wr_overrun,
   output logic [YB-1:0]       curr_vid_row,
   output logic                next_field_out,
   input  logic                lcd_next_pixel,
   output logic                lcd_newfield,
   output logic                lcd_wait,
   output logic [PIX_W-1:0]    lcd_pixel,
   input  logic                fetch_next,
   input  logic                next_line,
   input  logic                next_field,
   output logic [PIX_W-1:0]    hdmi_pixel,
   output logic                hdmi_underflow
);

   localparam int unsigned LB    = $clog2(LINES);
   localparam int unsigned AW    = LB + XB;
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned XCW   = $clog2(X_PER + 1);
   localparam int unsigned YCW   = $clog2(Y_PER + 1);
   localparam int unsigned SKW   = $clog2(TOP_SKIP + 2);
   localparam int unsigned LIMW  = YB + 1;

   localparam logic [XB-1:0] X_LAST = XB'(FB_W - 1);
   localparam logic [YB-1:0] Y_LAST = YB'(FB_H - 1);

   function automatic logic [YB-1:0] bin2gray(input logic [YB-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [YB-1:0] gray2bin(input logic [YB-1:0] g);
      logic [YB-1:0] b;
      b = g;
      for (int i = 1; i < int'(YB); i++) b = b ^ (g >> i);
      return b;
   endfunction

   // Two RAM copies so HDMI and LCD each own a read port
   logic [PIX_W-1:0] ram0 [DEPTH];
   logic [PIX_W-1:0] ram1 [DEPTH];

   // Renderer side
   logic [YB-1:0] wr_y_c;
   logic [XB-1:0] wr_x_c;
   logic [AW-1:0] wr_addr_c;
   logic          wr_accept_c;
   logic [YB-1:0] last_wr_row;
   logic [YB-1:0] last_wr_gray;

   // HDMI side (pixel_clk)
   logic            reset_px_meta;
   logic            reset_px;
   logic [YB-1:0]   wr_gray_px1;
   logic [YB-1:0]   wr_gray_px2;
   logic [YB-1:0]   wr_row_px_c;
   logic [XB-1:0]   hx;
   logic [YB-1:0]   hy;
   logic [XCW-1:0]  x_ctr;
   logic [YCW-1:0]  y_ctr;
   logic [SKW-1:0]  skip;
   logic [YB-1:0]   hy_gray;

   // clk-side synchronisers and LCD
   logic [YB-1:0]   vid_gray_s1;
   logic [YB-1:0]   vid_gray_s2;
   logic            nf_s1;
   logic            nf_s2;
   logic [YB-1:0]   lcd_row;
   logic [XB-1:0]   lcd_x;
   logic            lcd_blocked_c;
   logic [YB-1:0]   min_row_c;
   logic [LIMW-1:0] lim_sum_c;

   assign wr_y_c      = addr[YB+XB-1:XB];
   assign wr_x_c      = addr[XB-1:0];
   assign wr_addr_c   = {wr_y_c[LB-1:0], wr_x_c};
   assign wr_accept_c = wen && (wr_y_c <= wr_row_limit);

   // Port A of both copies: writes, plus read-before-write read-back from copy 0
   always_ff @(posedge clk) begin
      if (wr_accept_c) begin
         ram0[wr_addr_c] <= data_in;
         ram1[wr_addr_c] <= data_in;
      end
      if (ren) data_out <= ram0[wr_addr_c];
   end

   // Write bookkeeping: overrun pulse and last-written row for the underflow check
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_overrun   <= 1'b0;
         last_wr_row  <= '0;
         last_wr_gray <= '0;
      end else begin
         wr_overrun   <= wen && !wr_accept_c;
         if (wr_accept_c) last_wr_row <= wr_y_c;
         last_wr_gray <= bin2gray(last_wr_row);
      end
   end

   // Reset synchroniser into pixel_clk
   always_ff @(posedge pixel_clk) begin
      reset_px_meta <= reset;
      reset_px      <= reset_px_meta;
   end

   // Last-written row into pixel_clk
   always_ff @(posedge pixel_clk) begin
      if (reset_px) begin
         wr_gray_px1 <= '0;
         wr_gray_px2 <= '0;
      end else begin
         wr_gray_px1 <= last_wr_gray;
         wr_gray_px2 <= wr_gray_px1;
      end
   end

   assign wr_row_px_c = gray2bin(wr_gray_px2);

   // HDMI source position with rational X/Y repeat patterns
   always_ff @(posedge pixel_clk) begin
      if (reset_px) begin
         hx             <= '0;
         hy             <= '0;
         x_ctr          <= '0;
         y_ctr          <= '0;
         skip           <= '0;
         hy_gray        <= '0;
         hdmi_underflow <= 1'b0;
      end else begin
         hy_gray <= bin2gray(hy);
         if (next_field) begin
            hx             <= '0;
            hy             <= '0;
            x_ctr          <= '0;
            y_ctr          <= '0;
            skip           <= '0;
            hdmi_underflow <= 1'b0;
         end else begin
            if (next_line) begin
               if (skip < SKW'(TOP_SKIP)) begin
                  skip <= skip + SKW'(1);
               end else begin
                  hx    <= '0;
                  y_ctr <= (y_ctr == YCW'(Y_PER - 1)) ? '0 : y_ctr + YCW'(1);
                  if ((y_ctr < YCW'(Y_ADV)) && (hy < Y_LAST)) hy <= hy + YB'(1);
               end
            end else if (fetch_next) begin
               x_ctr <= (x_ctr == XCW'(X_PER - 1)) ? '0 : x_ctr + XCW'(1);
               if ((x_ctr < XCW'(X_ADV)) && (hx < X_LAST)) hx <= hx + XB'(1);
            end
            if (hy > wr_row_px_c) hdmi_underflow <= 1'b1;
         end
      end
   end

   // Copy 0 port B: HDMI read
   always_ff @(posedge pixel_clk) begin
      hdmi_pixel <= ram0[{hy[LB-1:0], hx}];
   end

   // HDMI row and next_field into clk
   always_ff @(posedge clk) begin
      if (reset) begin
         vid_gray_s1    <= '0;
         vid_gray_s2    <= '0;
         curr_vid_row   <= '0;
         nf_s1          <= 1'b0;
         nf_s2          <= 1'b0;
         next_field_out <= 1'b0;
      end else begin
         vid_gray_s1    <= hy_gray;
         vid_gray_s2    <= vid_gray_s1;
         curr_vid_row   <= gray2bin(vid_gray_s2);
         nf_s1          <= next_field;
         nf_s2          <= nf_s1;
         next_field_out <= nf_s2;
      end
   end

   // Renderer may run LINES-1 rows ahead of the slower reader
   assign min_row_c = (curr_vid_row < lcd_row) ? curr_vid_row : lcd_row;
   assign lim_sum_c = {1'b0, min_row_c} + LIMW'(LINES - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_row_limit <= YB'(LINES - 1);
      end else if (lim_sum_c > LIMW'(FB_H - 1)) begin
         wr_row_limit <= Y_LAST;
      end else begin
         wr_row_limit <= lim_sum_c[YB-1:0];
      end
   end

   // LCD never moves past the last pixel of the row HDMI is showing
   assign lcd_blocked_c = (lcd_row == curr_vid_row) && (lcd_x == X_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         lcd_row      <= '0;
         lcd_x        <= '0;
         lcd_wait     <= 1'b0;
         lcd_newfield <= 1'b0;
      end else begin
         lcd_wait     <= lcd_blocked_c;
         lcd_newfield <= 1'b0;
         if (lcd_next_pixel && !lcd_blocked_c) begin
            if (lcd_x < X_LAST) begin
               lcd_x <= lcd_x + XB'(1);
            end else begin
               lcd_x <= '0;
               if (lcd_row < Y_LAST) begin
                  lcd_row <= lcd_row + YB'(1);
               end else begin
                  lcd_row      <= '0;
                  lcd_newfield <= 1'b1;
               end
            end
         end
      end
   end

   // Copy 1 port B: LCD read
   always_ff @(posedge clk) begin
      lcd_pixel <= ram1[{lcd_row[LB-1:0], lcd_x}];
   end

endmodule

// File: tb/tb_video_linebuf_scaler.sv
// Directed self-checking bench for video_linebuf_scaler. FB_H is reduced so
// the LCD can traverse a whole field in a short run; all other parameters
// keep their defaults.
module tb_video_linebuf_scaler;

   localparam int unsigned PIX_W   = 24;
   localparam int unsigned XB      = 9;
   localparam int unsigned YB      = 11;
   localparam int unsigned FB_W    = 480;
   localparam int unsigned TB_FB_H = 16;

   logic              clk = 1'b0;
   logic              pixel_clk = 1'b0;
   logic              reset = 1'b1;
   logic [YB+XB-1:0]  addr = '0;
   logic [PIX_W-1:0]  data_in = '0;
   logic              wen = 1'b0;
   logic              ren = 1'b0;
   logic [PIX_W-1:0]  data_out;
   logic [YB-1:0]     wr_row_limit;
   logic              wr_overrun;
   logic [YB-1:0]     curr_vid_row;
   logic              next_field_out;
   logic              lcd_next_pixel = 1'b0;
   logic              lcd_newfield;
   logic              lcd_wait;
   logic [PIX_W-1:0]  lcd_pixel;
   logic              fetch_next = 1'b0;
   logic              next_line = 1'b0;
   logic              next_field = 1'b0;
   logic [PIX_W-1:0]  hdmi_pixel;
   logic              hdmi_underflow;

   int n_checks = 0;
   int n_fail   = 0;

   video_linebuf_scaler #(.FB_H(TB_FB_H)) dut (
      .clk            (clk),
      .reset          (reset),
      .pixel_clk      (pixel_clk),
      .addr           (addr),
      .data_in        (data_in),
      .wen            (wen),
      .ren            (ren),
      .data_out       (data_out),
      .wr_row_limit   (wr_row_limit),
      .wr_overrun     (wr_overrun),
      .curr_vid_row   (curr_vid_row),
      .next_field_out (next_field_out),
      .lcd_next_pixel (lcd_next_pixel),
      .lcd_newfield   (lcd_newfield),
      .lcd_wait       (lcd_wait),
      .lcd_pixel      (lcd_pixel),
      .fetch_next     (fetch_next),
      .next_line      (next_line),
      .next_field     (next_field),
      .hdmi_pixel     (hdmi_pixel),
      .hdmi_underflow (hdmi_underflow)
   );

   always #5 clk = ~clk;
   always #7 pixel_clk = ~pixel_clk;

   function automatic logic [PIX_W-1:0] pix(input int y, input int x);
      return PIX_W'((y << XB) | x);
   endfunction

   function automatic logic [YB+XB-1:0] mk_addr(input int y, input int x);
      return (YB+XB)'((y << XB) | x);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One pixel_clk strobe; returns after the pixel read register has updated
   task automatic px_pulse(input int sel);
      @(negedge pixel_clk);
      case (sel)
         0: fetch_next = 1'b1;
         1: next_line  = 1'b1;
         default: next_field = 1'b1;
      endcase
      @(negedge pixel_clk);
      fetch_next = 1'b0;
      next_line  = 1'b0;
      next_field = 1'b0;
      @(negedge pixel_clk);
   endtask

   task automatic px_lines(input int n);
      for (int i = 0; i < n; i++) px_pulse(1);
   endtask

   task automatic rd(input int y, input int x);
      @(negedge clk);
      addr = mk_addr(y, x);
      ren  = 1'b1;
      @(negedge clk);
      ren  = 1'b0;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int xs [8] = '{1, 2, 3, 3, 4, 5, 6, 6};
      int ys [6] = '{2, 2, 3, 4, 4, 5};
      bit done;

      // Reset state
      clks(10);
      reset = 1'b0;
      clks(10);
      check("rst_limit", 32'(wr_row_limit), 32'd3);
      check("rst_overrun", 32'(wr_overrun), 32'd0);
      check("rst_vid_row", 32'(curr_vid_row), 32'd0);
      check("rst_nf_out", 32'(next_field_out), 32'd0);
      check("rst_lcd_wait", 32'(lcd_wait), 32'd0);
      check("rst_newfield", 32'(lcd_newfield), 32'd0);
      check("rst_underflow", 32'(hdmi_underflow), 32'd0);

      // Fill rows 0..3 with pixel = {row, x}
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < int'(FB_W); x++) begin
            @(negedge clk);
            addr    = mk_addr(y, x);
            data_in = pix(y, x);
            wen     = 1'b1;
         end
      end
      @(negedge clk);
      wen = 1'b0;
      check("fill_no_overrun", 32'(wr_overrun), 32'd0);

      // Row 4 is beyond the limit and must be dropped
      @(negedge clk);
      addr    = mk_addr(4, 7);
      data_in = 24'hABCDEF;
      wen     = 1'b1;
      @(negedge clk);
      wen = 1'b0;
      check("overrun_pulse", 32'(wr_overrun), 32'd1);
      @(negedge clk);
      check("overrun_clear", 32'(wr_overrun), 32'd0);
      check("limit_after_fill", 32'(wr_row_limit), 32'd3);
      rd(0, 7);
      check("dropped_kept", 32'(data_out), 32'(pix(0, 7)));
      rd(1, 5);
      check("readback", 32'(data_out), 32'(pix(1, 5)));

      // Simultaneous write and read at one address returns the old data
      @(negedge clk);
      addr    = mk_addr(3, 9);
      data_in = 24'h123456;
      wen     = 1'b1;
      ren     = 1'b1;
      @(negedge clk);
      wen = 1'b0;
      ren = 1'b0;
      check("rw_old_data", 32'(data_out), 32'(pix(3, 9)));
      rd(3, 9);
      check("rw_new_data", 32'(data_out), 32'h123456);

      // LCD runs to x=479 of row 0 and stops there while HDMI is on row 0
      @(negedge clk);
      lcd_next_pixel = 1'b1;
      clks(484);
      lcd_next_pixel = 1'b0;
      check("lcd_block_wait", 32'(lcd_wait), 32'd1);
      check("lcd_block_pixel", 32'(lcd_pixel), 32'(pix(0, 479)));

      // HDMI field: top skip lines, then the x repeat pattern
      px_pulse(2);
      px_lines(38);
      clks(6);
      check("skip_vid_row", 32'(curr_vid_row), 32'd0);
      check("skip_lcd_wait", 32'(lcd_wait), 32'd1);
      px_lines(1);
      check("line1_pixel", 32'(hdmi_pixel), 32'(pix(1, 0)));
      clks(6);
      check("line1_vid_row", 32'(curr_vid_row), 32'd1);
      check("lcd_unblock", 32'(lcd_wait), 32'd0);
      @(negedge clk);
      lcd_next_pixel = 1'b1;
      @(negedge clk);
      lcd_next_pixel = 1'b0;
      @(negedge clk);
      check("lcd_next_row", 32'(lcd_pixel), 32'(pix(1, 0)));

      for (int i = 0; i < 8; i++) begin
         px_pulse(0);
         check($sformatf("hx_seq%0d", i), 32'(hdmi_pixel), 32'(pix(1, xs[i])));
      end

      // y pattern, x restart on a line, and underflow once past row 3
      for (int i = 0; i < 6; i++) begin
         px_lines(1);
         if (i == 0) check("line_x_restart", 32'(hdmi_pixel), 32'(pix(2, 0)));
         clks(6);
         check($sformatf("hy_seq%0d", i), 32'(curr_vid_row), 32'(ys[i]));
         check($sformatf("underflow%0d", i), 32'(hdmi_underflow), (ys[i] > 3) ? 32'd1 : 32'd0);
      end
      check("limit_row5", 32'(wr_row_limit), 32'd4);

      // y saturates at the last row
      px_lines(20);
      clks(6);
      check("hy_saturate", 32'(curr_vid_row), 32'(TB_FB_H - 1));
      check("underflow_sticky", 32'(hdmi_underflow), 32'd1);

      // LCD runs to the end of the last row, blocked behind HDMI
      @(negedge clk);
      lcd_next_pixel = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20000 && !done; i++) begin
         @(negedge clk);
         if (lcd_wait) done = 1'b1;
      end
      lcd_next_pixel = 1'b0;
      check("lcd_run_to_end", 32'(lcd_wait), 32'd1);
      clks(2);
      check("lcd_last_pixel", 32'(lcd_pixel), 32'(pix(3, 479)));
      check("limit_saturate", 32'(wr_row_limit), 32'(TB_FB_H - 1));

      // Held next_field: synchronised copy, underflow cleared, row back to 0
      @(negedge pixel_clk);
      next_field = 1'b1;
      repeat (4) @(negedge pixel_clk);
      next_field = 1'b0;
      @(negedge clk);
      check("nf_out_high", 32'(next_field_out), 32'd1);
      clks(10);
      check("nf_out_low", 32'(next_field_out), 32'd0);
      check("underflow_cleared", 32'(hdmi_underflow), 32'd0);
      check("field_vid_row", 32'(curr_vid_row), 32'd0);
      check("wrap_unblocked", 32'(lcd_wait), 32'd0);

      // LCD wraps from the last row to row 0 with a single newfield pulse
      @(negedge clk);
      lcd_next_pixel = 1'b1;
      @(negedge clk);
      lcd_next_pixel = 1'b0;
      check("newfield_pulse", 32'(lcd_newfield), 32'd1);
      @(negedge clk);
      check("newfield_single", 32'(lcd_newfield), 32'd0);
      check("wrap_pixel", 32'(lcd_pixel), 32'(pix(0, 0)));
      @(negedge clk);
      lcd_next_pixel = 1'b1;
      clks(485);
      lcd_next_pixel = 1'b0;
      check("wrap_row0_block", 32'(lcd_wait), 32'd1);
      check("wrap_row0_pixel", 32'(lcd_pixel), 32'(pix(0, 479)));

      // Put both readers mid-line, with underflow set, then reset
      px_lines(43);
      px_pulse(0);
      px_pulse(0);
      px_pulse(0);
      check("pre_rst_hdmi", 32'(hdmi_pixel), 32'(pix(0, 3)));
      check("pre_rst_underflow", 32'(hdmi_underflow), 32'd1);
      clks(6);
      @(negedge clk);
      lcd_next_pixel = 1'b1;
      clks(10);
      lcd_next_pixel = 1'b0;
      @(negedge clk);
      check("pre_rst_lcd", 32'(lcd_pixel), 32'(pix(1, 9)));

      @(negedge clk);
      reset = 1'b1;
      clks(6);
      reset = 1'b0;
      clks(8);
      check("mid_rst_hdmi", 32'(hdmi_pixel), 32'(pix(0, 0)));
      check("mid_rst_underflow", 32'(hdmi_underflow), 32'd0);
      check("mid_rst_vid_row", 32'(curr_vid_row), 32'd0);
      check("mid_rst_lcd", 32'(lcd_pixel), 32'(pix(0, 0)));
      check("mid_rst_lcd_wait", 32'(lcd_wait), 32'd0);
      check("mid_rst_limit", 32'(wr_row_limit), 32'd3);
      check("mid_rst_nf_out", 32'(next_field_out), 32'd0);
      rd(1, 5);
      check("mid_rst_ring_kept", 32'(data_out), 32'(pix(1, 5)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
